// File: rtl/imem_pkg.sv
// Shared instruction-word layout and loader state encoding for the 9-bit instruction store.
package imem_pkg;
    localparam int INSTR_W         = 9;
    localparam int OP_MSB          = 8;
    localparam int OP_LSB          = 6;
    localparam int R1_MSB          = 5;
    localparam int R1_LSB          = 3;
    localparam int R2_MSB          = 2;
    localparam int R2_LSB          = 0;
    localparam int PC_BITS_DEFAULT = 12;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CHK,
        DONE
    } loader_state_t;
endpackage

// File: rtl/imem_word_pack.sv
// Holds the low byte of a word and joins it with the high byte into one instruction word.
module imem_word_pack
    import imem_pkg::*;
(
    input  logic               clk,
    input  logic               lo_load,
    input  logic [7:0]         lo_byte,
    input  logic [7:0]         hi_byte,
    output logic [INSTR_W-1:0] word,
    output logic               fmt_bad
);
    logic [7:0] lo_p0;

    // Stage p0: low byte held until the matching high byte arrives
    always_ff @(posedge clk) begin
        if (lo_load) begin
            lo_p0 <= lo_byte;
        end
    end

    assign word    = {hi_byte[0], lo_p0};
    assign fmt_bad = |hi_byte[7:1];
endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction store: two bytes per word, auto-incrementing address.
// Optional trailing checksum byte and cksum_err port when LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_pkg::*;
#(
    parameter int PC_BITS = PC_BITS_DEFAULT,
    parameter int INSTR_W = imem_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_BITS-1:0] base_addr,
    input  logic [PC_BITS-1:0] word_count,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               wr_en,
    output logic [PC_BITS-1:0] wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
`ifdef LOADER_CHECKSUM_EN
    output logic               cksum_err,
`endif
    output logic               fmt_err
);
    loader_state_t state, state_nx;

    logic [PC_BITS-1:0] addr, remaining;
    logic [PC_BITS-1:0] addr_p1;
    logic [INSTR_W-1:0] data_p1;
    logic               vld_p1;
    logic [INSTR_W-1:0] word;
    logic               fmt_bad;
    logic               hs, lo_hs, hi_hs, go;

    assign hs    = in_valid && in_ready;
    assign lo_hs = hs && (state == LO);
    assign hi_hs = hs && (state == HI);
    assign go    = start && (state == IDLE);

    imem_word_pack u_pack (
        .clk     (clk),
        .lo_load (lo_hs),
        .lo_byte (in_byte),
        .hi_byte (in_byte),
        .word    (word),
        .fmt_bad (fmt_bad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (word_count != '0) ? LO : DONE;
                end
            end
            LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = HI;
                end
            end
            HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef LOADER_CHECKSUM_EN
                    state_nx = (remaining == PC_BITS'(1)) ? CHK : LO;
`else
                    state_nx = (remaining == PC_BITS'(1)) ? DONE : LO;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = DONE;
                end
            end
`endif
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p1: write port registered one cycle after the high-byte handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            remaining <= '0;
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            data_p1   <= '0;
            fmt_err   <= 1'b0;
        end else begin
            vld_p1 <= hi_hs;
            if (go) begin
                addr      <= base_addr;
                remaining <= word_count;
                fmt_err   <= 1'b0;
            end
            if (hi_hs) begin
                addr_p1   <= addr;
                data_p1   <= word;
                addr      <= addr + PC_BITS'(1);
                remaining <= remaining - PC_BITS'(1);
                if (fmt_bad) begin
                    fmt_err <= 1'b1;
                end
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum      <= '0;
            cksum_err <= 1'b0;
        end else begin
            if (go) begin
                csum      <= '0;
                cksum_err <= 1'b0;
            end else if (lo_hs || hi_hs) begin
                csum <= csum ^ in_byte;
            end else if (hs && (state == CHK) && (in_byte != csum)) begin
                cksum_err <= 1'b1;
            end
        end
    end
`endif

    assign wr_en   = vld_p1;
    assign wr_addr = addr_p1;
    assign wr_data = data_p1;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected write/done events queued by stimulus, popped by a monitor.
module tb_imem_loader;
    localparam int PB = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PB-1:0] base_addr = '0;
    logic [PB-1:0] word_count = '0;
    logic [7:0]    in_byte = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, wr_en, busy, done, fmt_err;
    logic [PB-1:0] wr_addr;
    logic [8:0]    wr_data;
`ifdef LOADER_CHECKSUM_EN
    logic          cksum_err;
    localparam bit LAST_DONE = 1'b0;
`else
    localparam bit LAST_DONE = 1'b1;
`endif

    typedef struct {
        bit         we;
        logic [11:0] a;
        logic [8:0]  d;
        bit         dn;
    } ev_t;
    ev_t q[$];

    int         total = 0;
    int         bad = 0;
    logic [7:0] run_x = '0;

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
`ifdef LOADER_CHECKSUM_EN
        .cksum_err  (cksum_err),
`endif
        .fmt_err    (fmt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (!reset && (wr_en || done)) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: wr_en=%0d done=%0d addr=%h data=%h, want no event",
                         wr_en, done, wr_addr, wr_data);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (wr_en !== e.we || done !== e.dn ||
                    (e.we && (wr_addr !== e.a || wr_data !== e.d))) begin
                    bad++;
                    $display("FAIL sb_event: got we=%0d addr=%h data=%h done=%0d, want we=%0d addr=%h data=%h done=%0d",
                             wr_en, wr_addr, wr_data, done, e.we, e.a, e.d, e.dn);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_ev(input bit we, input logic [11:0] a, input logic [8:0] d, input bit dn);
        ev_t e;
        e.we = we;
        e.a  = a;
        e.d  = d;
        e.dn = dn;
        q.push_back(e);
    endtask

    task automatic do_start(input logic [PB-1:0] b, input logic [PB-1:0] c);
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        run_x      = '0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL handshake_timeout: in_ready=0 after %0d cycles, want 1", n);
            in_valid = 1'b0;
            return;
        end
        run_x = run_x ^ b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout_busy", busy, 0);
    endtask

    task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] cs;
        cs = run_x;
        push_ev(1'b0, '0, '0, 1'b1);
        send_byte(cs);
        wait_idle();
        check("cksum_err_good", cksum_err, 0);
`else
        wait_idle();
`endif
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_fmt_err", fmt_err, 0);
        reset = 1'b0;
        @(negedge clk);

        // basic two-word load
        push_ev(1'b1, 12'h010, 9'h1C5, 1'b0);
        push_ev(1'b1, 12'h011, 9'h03A, LAST_DONE);
        do_start(12'h010, 12'd2);
        check("busy_after_start", busy, 1);
        send_byte(8'hC5);
        send_byte(8'h01);
        send_byte(8'h3A);
        send_byte(8'h00);
        finish_load();
        check("basic_fmt_err", fmt_err, 0);

        // address wrap
        push_ev(1'b1, 12'hFFF, 9'h011, 1'b0);
        push_ev(1'b1, 12'h000, 9'h122, LAST_DONE);
        do_start(12'hFFF, 12'd2);
        send_byte(8'h11);
        send_byte(8'h00);
        send_byte(8'h22);
        send_byte(8'h01);
        finish_load();

        // stall between low and high byte
        push_ev(1'b1, 12'h100, 9'h105, LAST_DONE);
        do_start(12'h100, 12'd1);
        send_byte(8'h05);
        for (int i = 0; i < 5; i++) begin
            check("stall_no_wr_en", wr_en, 0);
            @(negedge clk);
        end
        send_byte(8'h01);
        check("stall_latency_wr_en", wr_en, 1);
        check("stall_wr_addr", wr_addr, 12'h100);
        @(negedge clk);
        check("wr_en_single_cycle", wr_en, 0);
        check("wr_addr_hold", wr_addr, 12'h100);
        finish_load();

        // zero-length load
        push_ev(1'b0, '0, '0, 1'b1);
        do_start(12'h123, 12'd0);
        check("zero_done_next_cycle", done, 1);
        wait_idle();

        // malformed high byte
        push_ev(1'b1, 12'h200, 9'h100, LAST_DONE);
        do_start(12'h200, 12'd1);
        send_byte(8'h00);
        send_byte(8'h03);
        finish_load();
        check("fmt_err_set", fmt_err, 1);

        // reset after a low-byte handshake
        do_start(12'h040, 12'd3);
        check("fmt_err_cleared_on_start", fmt_err, 0);
        send_byte(8'hAA);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_busy", busy, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_done", done, 0);
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_wr_data", wr_data, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_write", wr_en, 0);
        push_ev(1'b1, 12'h020, 9'h007, LAST_DONE);
        do_start(12'h020, 12'd1);
        send_byte(8'h07);
        send_byte(8'h00);
        finish_load();

`ifdef LOADER_CHECKSUM_EN
        // checksum match and mismatch
        push_ev(1'b1, 12'h300, 9'h012, 1'b0);
        push_ev(1'b1, 12'h301, 9'h134, 1'b0);
        push_ev(1'b0, '0, '0, 1'b1);
        do_start(12'h300, 12'd2);
        send_byte(8'h12);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h01);
        send_byte(8'h27);
        wait_idle();
        check("cksum_ok", cksum_err, 0);
        push_ev(1'b1, 12'h300, 9'h012, 1'b0);
        push_ev(1'b1, 12'h301, 9'h134, 1'b0);
        push_ev(1'b0, '0, '0, 1'b1);
        do_start(12'h300, 12'd2);
        send_byte(8'h12);
        send_byte(8'h00);
        send_byte(8'h34);
        send_byte(8'h01);
        send_byte(8'h26);
        wait_idle();
        check("cksum_bad", cksum_err, 1);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the 9-bit instruction memory. It accepts a byte stream over a valid/ready handshake and packs every two bytes into one 9-bit instruction word: opcode[8:6], reg1[5:3], reg2[2:0].
- Each word is written through a synchronous write port at an auto-incrementing PC address.
- Used by the boot/test harness to program the core's instruction store at runtime, instead of loading it from a file at elaboration.

Parameters:
- PC_BITS, 12, address width of the instruction memory; the address space is 2**PC_BITS words.
- INSTR_W, 9, instruction word width; fixed by the ISA and must not be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  PC_BITS  first write address; captured on start.
- word_count  input  PC_BITS  number of words to load; captured on start; 0 means no words.
- in_byte  input  8  stream byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader accepts in_byte this cycle.
- wr_en  output  1  one-cycle write strobe to the instruction memory.
- wr_addr  output  PC_BITS  write address.
- wr_data  output  INSTR_W  write data.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load completes.
- fmt_err  output  1  sticky; set when a high byte has a nonzero bit in [7:1]; cleared on start.

Behaviour:
- Reset: all outputs are 0; state is IDLE; address and count registers are 0; fmt_err is 0.
- A byte is accepted ("handshake") in any cycle where in_valid && in_ready.
- States:
  - IDLE: in_ready=0.
    - start=1 and word_count!=0 -> go to LO; capture base_addr and word_count; clear fmt_err.
    - start=1 and word_count==0 -> go to DONE.
  - LO: in_ready=1. On handshake, latch the low byte as word[7:0] and go to HI.
  - HI: in_ready=1. On handshake, word[8]=in_byte[0].
    - If in_byte[7:1]!=0, set fmt_err; the word is still written.
    - Register the write: on the next cycle wr_en=1 with wr_addr=current address and wr_data=assembled word.
    - Then increment the address modulo 2**PC_BITS (wraps from 0xFFF to 0x000 at the default width) and decrement the remaining count.
    - If remaining count was 1 -> go to DONE (or CHK when LOADER_CHECKSUM_EN is defined); otherwise -> go to LO.
  - DONE: done=1 for exactly one cycle, in_ready=0, then go to IDLE.
- Latency: wr_en rises exactly 1 cycle after the high-byte handshake. For the last word, wr_en and done are asserted in the same cycle.
- wr_en is never high for two consecutive cycles; the minimum spacing is 2 cycles (two handshakes per word).
- wr_addr and wr_data hold their last values while wr_en=0.
- start while busy is ignored.
- in_valid deasserted mid-word stalls the loader in LO or HI indefinitely; no timeout.
- Asynchronous reset mid-load returns to IDLE immediately. A half-assembled word is discarded and never written. A wr_en already registered is cleared.
- A wrap-around that overwrites earlier words (word_count > 2**PC_BITS - base_addr) is legal and is not flagged.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every accepted LO and HI byte of the load; it is cleared on start.
  - After the last word, the loader enters state CHK with in_ready=1 and accepts one checksum byte.
  - On that handshake, go to DONE. Output port cksum_err (1 bit, sticky, cleared on start) is set if the checksum byte != the running XOR.
  - wr_en for the last word still occurs 1 cycle after its HI handshake; done follows the CHK handshake.
- Undefined: no CHK state and no cksum_err port; behaviour exactly as in Behaviour.

Decomposition:
- Package imem_pkg holds:
  - INSTR_W=9 and the opcode/reg field positions (OP_MSB=8, OP_LSB=6, R1_MSB=5, R1_LSB=3, R2_MSB=2, R2_LSB=0), shared with the instruction memory reader.
  - Default PC_BITS=12.
  - enum loader_state_t {IDLE, LO, HI, CHK, DONE}.
- One sub-module is natural: imem_word_pack. It is combinational plus the LO latch: inputs are the low byte and the high byte; outputs are the 9-bit word and fmt_bad.

Test Plan:
- Basic load: base_addr=0x010, word_count=2, bytes 0xC5,0x01,0x3A,0x00 -> wr_en at 0x010 data 0x1C5, then at 0x011 data 0x03A; done pulses with the second write; fmt_err=0.
- Wrap-around: base_addr=0xFFF, word_count=2 -> writes at 0xFFF then 0x000.
- Backpressure/stall: in_valid low for 5 cycles between LO and HI -> no wr_en until the HI handshake; wr_en exactly 1 cycle after it.
- Edge cases:
  - word_count=0 -> done the cycle after start, no wr_en.
  - High byte 0x03 -> word[8]=1 and fmt_err=1, with the write still performed.
- Reset after an LO handshake (word_count=3) -> no wr_en ever; outputs 0. A following load at base_addr=0x020 starts cleanly.
- With LOADER_CHECKSUM_EN: bytes 0x12,0x00,0x34,0x01 then checksum 0x27 -> cksum_err=0. Checksum 0x26 -> cksum_err=1.
